// File: rtl/imm_extend_buf.sv
// Immediate-extension unit feeding a 2-entry FIFO with valid/ready on both sides.
// Each accepted immediate is extended at push time according to its mode tag.
module imm_extend_buf #(
    parameter int IN_W  = 8,
    parameter int OUT_W = 16,
    parameter int SHIFT = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IN_W-1:0]  in_data,
    input  logic [1:0]       in_mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out_data,
    output logic [1:0]       out_mode
);

    localparam int EXT_W = OUT_W - IN_W;

    typedef enum logic [1:0] {
        MODE_SEXT     = 2'd0,
        MODE_ZEXT     = 2'd1,
        MODE_SEXT_SHL = 2'd2,
        MODE_UPPER    = 2'd3
    } mode_e;

    logic [OUT_W-1:0] mem_data [2];
    logic [1:0]       mem_mode [2];
    logic             head;
    logic             tail;
    logic [1:0]       count;
    logic [1:0]       count_next;
    logic             push;
    logic             pop;
    logic [OUT_W-1:0] sext_data;
    logic [OUT_W-1:0] ext_data;

    // NOTE: every combinational output gets a default first, so no path can infer a latch.
    always_comb begin
        sext_data = {{EXT_W{in_data[IN_W-1]}}, in_data};
        ext_data  = sext_data;
        case (mode_e'(in_mode))
            MODE_SEXT:     ext_data = sext_data;
            MODE_ZEXT:     ext_data = {{EXT_W{1'b0}}, in_data};
            // SHIFT never exceeds EXT_W, so only sign copies fall off the top.
            MODE_SEXT_SHL: ext_data = sext_data << SHIFT;
            MODE_UPPER:    ext_data = {in_data, {EXT_W{1'b0}}};
            default:       ext_data = sext_data;
        endcase
    end

    assign out_valid = (count != 2'd0);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    always_comb begin
        count_next = count;
        case ({push, pop})
            2'b10:   count_next = count + 2'd1;
            2'b01:   count_next = count - 2'd1;
            default: count_next = count;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only; the storage array is
    // reset as well so the head entry presents zero data straight out of reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count    <= 2'd0;
            head     <= 1'b0;
            tail     <= 1'b0;
            in_ready <= 1'b1;
            for (int i = 0; i < 2; i++) begin
                mem_data[i] <= '0;
                mem_mode[i] <= '0;
            end
        end else if (flush) begin
            // Flush wins over a same-cycle push or pop; the offered item is dropped.
            count    <= 2'd0;
            head     <= 1'b0;
            tail     <= 1'b0;
            in_ready <= 1'b1;
        end else begin
            count    <= count_next;
            in_ready <= (count_next < 2'd2);
            if (push) begin
                mem_data[tail] <= ext_data;
                mem_mode[tail] <= in_mode;
                tail           <= ~tail;
            end
            if (pop) begin
                head <= ~head;
            end
        end
    end

    // Head entry comes straight from registers, so outputs move only on clock edges.
    assign out_data = mem_data[head];
    assign out_mode = mem_mode[head];

endmodule

// File: tb/tb_imm_extend_buf.sv
// Directed bench for imm_extend_buf: a scoreboard queue tracks pushed items and is
// compared against every pop; a second instance covers the wide parameter set.
module tb_imm_extend_buf;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [7:0]  in_data = '0;
    logic [1:0]  in_mode = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [15:0] out_data;
    logic [1:0]  out_mode;

    logic        in_valid2 = 1'b0;
    logic        in_ready2;
    logic [11:0] in_data2 = '0;
    logic [1:0]  in_mode2 = '0;
    logic        out_valid2;
    logic [31:0] out_data2;
    logic [1:0]  out_mode2;

    typedef struct packed {
        logic [15:0] data;
        logic [1:0]  mode;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    imm_extend_buf dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_mode   (in_mode),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_mode  (out_mode)
    );

    imm_extend_buf #(.IN_W(12), .OUT_W(32), .SHIFT(2)) dut_wide (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .in_valid  (in_valid2),
        .in_ready  (in_ready2),
        .in_data   (in_data2),
        .in_mode   (in_mode2),
        .out_valid (out_valid2),
        .out_ready (1'b1),
        .out_data  (out_data2),
        .out_mode  (out_mode2)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference extension for the default 8 -> 16, SHIFT=1 instance.
    function automatic logic [15:0] model(input logic [7:0] d, input logic [1:0] m);
        logic signed [15:0] s;
        s = $signed(d);
        case (m)
            2'd0:    return s;
            2'd1:    return 16'(d);
            2'd2:    return 16'(s * 16'sd2);
            default: return 16'(d) << 8;
        endcase
    endfunction

    // One clock: check status and any pop against the scoreboard, record any push.
    task automatic step();
        exp_t e;
        check("out_valid", 32'(out_valid), 32'(sb.size() != 0));
        check("in_ready", 32'(in_ready), 32'(sb.size() < 2));
        if (out_valid && out_ready && sb.size() > 0) begin
            e = sb.pop_front();
            check("out_data", 32'(out_data), 32'(e.data));
            check("out_mode", 32'(out_mode), 32'(e.mode));
        end
        if (flush) begin
            sb.delete();
        end else if (in_valid && in_ready) begin
            e.data = model(in_data, in_mode);
            e.mode = in_mode;
            sb.push_back(e);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic offer(input logic [7:0] d, input logic [1:0] m);
        in_valid = 1'b1;
        in_data  = d;
        in_mode  = m;
        step();
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        for (int i = 0; i < n; i++) step();
    endtask

    initial begin
        out_ready = 1'b1;
        #12;
        check("rst_out_valid", 32'(out_valid), 32'h0);
        check("rst_in_ready", 32'(in_ready), 32'h1);
        check("rst_out_data", 32'(out_data), 32'h0);
        check("rst_out_mode", 32'(out_mode), 32'h0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Basic sign extension, one cycle latency.
        offer(8'hF0, 2'd0);
        check("lat_fff0", 32'(out_data), 32'hFFF0);
        offer(8'h0F, 2'd0);
        check("lat_000f", 32'(out_data), 32'h000F);
        idle(2);

        // Remaining modes back to back.
        offer(8'hF0, 2'd1);
        check("zext", 32'(out_data), 32'h00F0);
        offer(8'h81, 2'd2);
        check("sext_shl", 32'(out_data), 32'hFF02);
        offer(8'hAB, 2'd3);
        check("upper", 32'(out_data), 32'hAB00);
        check("upper_mode", 32'(out_mode), 32'h3);
        idle(2);

        // Backpressure: third item held upstream while full.
        out_ready = 1'b0;
        offer(8'h01, 2'd1);
        offer(8'h02, 2'd1);
        check("full_in_ready", 32'(in_ready), 32'h0);
        offer(8'h03, 2'd1);
        step();
        step();
        check("stall_hold", 32'(out_data), 32'h0001);
        out_ready = 1'b1;
        step();
        check("ready_return", 32'(in_ready), 32'h1);
        step();
        idle(3);

        // Streaming at count 1: one push and one pop every cycle.
        offer(8'h80, 2'd0);
        for (int i = 1; i < 9; i++) begin
            offer(8'(8'h80 + i), 2'd0);
            check("stream_valid", 32'(out_valid), 32'h1);
        end
        idle(3);

        // Flush at count 2 with an offered item.
        out_ready = 1'b0;
        offer(8'h11, 2'd0);
        offer(8'h22, 2'd1);
        flush    = 1'b1;
        in_valid = 1'b1;
        in_data  = 8'h33;
        step();
        flush = 1'b0;
        check("flush_valid", 32'(out_valid), 32'h0);
        check("flush_ready", 32'(in_ready), 32'h1);
        // Flush at count 1 where the offered item would be accepted.
        offer(8'h44, 2'd0);
        flush   = 1'b1;
        in_data = 8'h55;
        step();
        flush     = 1'b0;
        out_ready = 1'b1;
        idle(3);

        // Asynchronous reset while full, between clock edges.
        out_ready = 1'b0;
        offer(8'h55, 2'd2);
        offer(8'h66, 2'd3);
        in_valid = 1'b0;
        #3;
        rst_n = 1'b0;
        #1;
        check("arst_out_valid", 32'(out_valid), 32'h0);
        check("arst_in_ready", 32'(in_ready), 32'h1);
        check("arst_out_data", 32'(out_data), 32'h0);
        check("arst_out_mode", 32'(out_mode), 32'h0);
        sb.delete();
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        offer(8'h7F, 2'd0);
        check("post_rst", 32'(out_data), 32'h007F);
        idle(2);

        // Wide parameter set.
        in_valid2 = 1'b1;
        in_data2  = 12'h800;
        in_mode2  = 2'd2;
        step();
        in_mode2  = 2'd3;
        check("wide_shl", out_data2, 32'hFFFFE000);
        check("wide_shl_mode", 32'(out_mode2), 32'h2);
        step();
        in_valid2 = 1'b0;
        check("wide_upper", out_data2, 32'h80000000);
        check("wide_upper_mode", 32'(out_mode2), 32'h3);
        step();
        check("wide_drain", 32'(out_valid2), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
